// File: rtl/rv32_pkg.sv
// rv32_pkg: shared constants and fetch-state encoding for the rv32 front end
package rv32_pkg;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0] WORD_BYTES = 32'd4;
    typedef enum logic {FETCH, DISCARD} fetch_state_t;
endpackage

// File: rtl/if_prefetch_buffer_if.sv
// if_prefetch_buffer_if: redirect, decode and instruction-memory signals of the fetch stage
interface if_prefetch_buffer_if;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic [31:0] imem_addr;
    logic        imem_read;
    logic [31:0] imem_readdata;
    logic        imem_busywait;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        instr_valid;
    modport master (
        input  branch_taken, branch_target, stall, imem_readdata, imem_busywait,
        output imem_addr, imem_read, instruction, pc, instr_valid
    );
    modport slave (
        output branch_taken, branch_target, stall, imem_readdata, imem_busywait,
        input  imem_addr, imem_read, instruction, pc, instr_valid
    );
endinterface

// File: rtl/if_prefetch_buffer_sync_fifo.sv
// sync_fifo: power-of-two FIFO with flush and a registered head that holds its last value when empty
module sync_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
    logic [AW:0] cnt_pop, cnt_next;
    logic do_push, do_pop;
    always_comb begin
        do_pop   = pop && !flush && count != '0;
        do_push  = push && !flush && (count != FULL || do_pop);
        cnt_pop  = count - (AW+1)'(do_pop);
        cnt_next = flush ? '0 : cnt_pop + (AW+1)'(do_push);
        rd_next  = rd_ptr + AW'(do_pop);
    end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    // head is loaded with the entry that will be at the front after this edge
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            rd_ptr <= flush ? '0 : rd_next;
            wr_ptr <= flush ? '0 : wr_ptr + AW'(do_push);
            count  <= cnt_next;
            if (cnt_next != '0) head <= cnt_pop == '0 ? din : mem[rd_next];
        end
    end
endmodule

// File: rtl/if_prefetch_buffer.sv
// if_prefetch_buffer: fetch PC owner, busywait memory requester and instruction prefetch FIFO
module if_prefetch_buffer
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input logic                 clk,
    input logic                 reset,
    if_prefetch_buffer_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    fetch_state_t state, state_next;
    logic [31:0] fetch_pc, fetch_pc_next, disc_addr, disc_addr_next;
    logic [AW:0] count;
    logic [63:0] head;
    logic done, outstanding, push, pop;
    assign bus.imem_read   = !reset && (state == DISCARD || count != FULL);
    assign bus.imem_addr   = state == DISCARD ? disc_addr : fetch_pc;
    assign bus.instr_valid = count != '0;
    assign bus.instruction = head[63:32];
    assign bus.pc          = head[31:0];
    // a redirect abandons the buffered words; an in-flight read is drained in DISCARD
    always_comb begin
        done           = bus.imem_read && !bus.imem_busywait;
        outstanding    = bus.imem_read && bus.imem_busywait;
        push           = state == FETCH && done;
        pop            = bus.instr_valid && !bus.stall && !bus.branch_taken;
        state_next     = bus.branch_taken ? (outstanding ? DISCARD : FETCH)
                       : (state == DISCARD && done) ? FETCH : state;
        fetch_pc_next  = bus.branch_taken ? bus.branch_target
                       : push ? fetch_pc + WORD_BYTES : fetch_pc;
        disc_addr_next = bus.branch_taken && outstanding ? bus.imem_addr : disc_addr;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            fetch_pc  <= RESET_PC;
            disc_addr <= RESET_PC;
        end else begin
            state     <= state_next;
            fetch_pc  <= fetch_pc_next;
            disc_addr <= disc_addr_next;
        end
    end
    sync_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (bus.branch_taken),
        .din   ({bus.imem_readdata, fetch_pc}),
        .head  (head),
        .count (count)
    );
endmodule

// File: tb/tb_if_prefetch_buffer.sv
// tb_if_prefetch_buffer: directed vector table plus hand sequences for the fetch stage
module tb_if_prefetch_buffer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    int row = 0;
    always #5 clk = ~clk;
    if_prefetch_buffer_if bus();
    assign bus.imem_readdata = bus.imem_addr + 32'h13;
    if_prefetch_buffer dut (.clk(clk), .reset(reset), .bus(bus.master));
    typedef struct {
        logic        rst, stall, br;
        logic [31:0] tgt;
        logic        busy;
        logic        valid;
        logic [31:0] pc;
        logic        read;
        logic [31:0] addr;
    } vec_t;
    vec_t tbl[$];
    function automatic vec_t mk(logic rst, logic stall, logic br, logic [31:0] tgt, logic busy,
                                logic valid, logic [31:0] pc, logic read, logic [31:0] addr);
        vec_t v;
        v.rst = rst; v.stall = stall; v.br = br; v.tgt = tgt; v.busy = busy;
        v.valid = valid; v.pc = pc; v.read = read; v.addr = addr;
        return v;
    endfunction
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%h expected=%h", name, row, act, exp);
        end
    endtask
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_read", {31'd0, bus.imem_read}, 32'd0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_instr", bus.instruction, 32'h0);
        reset = 1'b0;
    endtask
    task automatic drive(logic stall, logic br, logic [31:0] tgt, logic busy);
        bus.stall = stall;
        bus.branch_taken = br;
        bus.branch_target = tgt;
        bus.imem_busywait = busy;
    endtask
    initial begin
        drive(0, 0, 0, 0);
        // zero-wait start, 5-cycle stall filling the FIFO, redirect to 0x100 with STALL
        tbl.push_back(mk(1,0,0,0,0,        0,32'h0,1,32'h0));
        tbl.push_back(mk(0,0,0,0,0,        1,32'h0,1,32'h4));
        tbl.push_back(mk(0,0,0,0,0,        1,32'h4,1,32'h8));
        tbl.push_back(mk(0,1,0,0,0,        1,32'h8,1,32'hC));
        tbl.push_back(mk(0,1,0,0,0,        1,32'h8,0,32'h10));
        tbl.push_back(mk(0,1,0,0,0,        1,32'h8,0,32'h10));
        tbl.push_back(mk(0,1,0,0,0,        1,32'h8,0,32'h10));
        tbl.push_back(mk(0,1,0,0,0,        1,32'h8,0,32'h10));
        tbl.push_back(mk(0,0,0,0,0,        1,32'h8,0,32'h10));
        tbl.push_back(mk(0,0,0,0,0,        1,32'hC,1,32'h10));
        tbl.push_back(mk(0,1,0,0,0,        1,32'h10,1,32'h14));
        tbl.push_back(mk(0,1,1,32'h100,0,  1,32'h10,0,32'h18));
        tbl.push_back(mk(0,0,0,0,0,        0,32'h10,1,32'h100));
        tbl.push_back(mk(0,0,0,0,0,        1,32'h100,1,32'h104));
        tbl.push_back(mk(0,0,0,0,0,        1,32'h104,1,32'h108));
        // busywait 3 cycles at 8, then redirect to 0x200 while 0x10 is busywaiting
        tbl.push_back(mk(1,0,0,0,0,        0,32'h0,1,32'h0));
        tbl.push_back(mk(0,0,0,0,0,        1,32'h0,1,32'h4));
        tbl.push_back(mk(0,0,0,0,1,        1,32'h4,1,32'h8));
        tbl.push_back(mk(0,0,0,0,1,        0,32'h4,1,32'h8));
        tbl.push_back(mk(0,0,0,0,1,        0,32'h4,1,32'h8));
        tbl.push_back(mk(0,0,0,0,0,        0,32'h4,1,32'h8));
        tbl.push_back(mk(0,0,0,0,0,        1,32'h8,1,32'hC));
        tbl.push_back(mk(0,0,1,32'h200,1,  1,32'hC,1,32'h10));
        tbl.push_back(mk(0,0,0,0,1,        0,32'hC,1,32'h10));
        tbl.push_back(mk(0,0,0,0,0,        0,32'hC,1,32'h10));
        tbl.push_back(mk(0,0,0,0,0,        0,32'hC,1,32'h200));
        tbl.push_back(mk(0,0,0,0,0,        1,32'h200,1,32'h204));
        // double redirect in DISCARD, PC wrap, redirect dropping a completing word
        tbl.push_back(mk(1,0,1,32'hFFFF_FFF8,1, 0,32'h0,1,32'h0));
        tbl.push_back(mk(0,0,1,32'hFFFF_FFFC,1, 0,32'h0,1,32'h0));
        tbl.push_back(mk(0,0,0,0,0,        0,32'h0,1,32'h0));
        tbl.push_back(mk(0,0,0,0,0,        0,32'h0,1,32'hFFFF_FFFC));
        tbl.push_back(mk(0,0,0,0,0,        1,32'hFFFF_FFFC,1,32'h0));
        tbl.push_back(mk(0,1,1,32'h40,0,   1,32'h0,1,32'h4));
        tbl.push_back(mk(0,0,0,0,0,        0,32'h0,1,32'h40));
        tbl.push_back(mk(0,0,0,0,0,        1,32'h40,1,32'h44));
        for (int i = 0; i < tbl.size(); i++) begin
            row = i;
            if (tbl[i].rst) do_reset();
            drive(tbl[i].stall, tbl[i].br, tbl[i].tgt, tbl[i].busy);
            #1;
            chk("valid", {31'd0, bus.instr_valid}, {31'd0, tbl[i].valid});
            chk("pc", bus.pc, tbl[i].pc);
            chk("read", {31'd0, bus.imem_read}, {31'd0, tbl[i].read});
            chk("addr", bus.imem_addr, tbl[i].addr);
            if (tbl[i].valid) chk("instr", bus.instruction, tbl[i].pc + 32'h13);
            @(posedge clk);
            #1;
        end
        // reset while a request is busywaiting, then sustained one-per-cycle throughput
        row = 1000;
        drive(0, 0, 0, 1);
        repeat (2) @(posedge clk);
        do_reset();
        drive(0, 0, 0, 0);
        #1;
        chk("tp_read0", {31'd0, bus.imem_read}, 32'd1);
        chk("tp_addr0", bus.imem_addr, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            row = 1000 + i;
            @(posedge clk);
            #1;
            chk("tp_valid", {31'd0, bus.instr_valid}, 32'd1);
            chk("tp_pc", bus.pc, 32'(i - 1) * 4);
            chk("tp_addr", bus.imem_addr, 32'(i) * 4);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
